// File: rtl/rv32i_types.sv
// Shared RV32 types for the front end: machine word, fetch FSM states and the
// pc/instruction pair carried between fetch and decode.
package rv32i_types;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] rv32i_word;

    localparam rv32i_word NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        DISCARD = 2'd1,
        FULL    = 2'd2
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_pkt_t;

    function automatic rv32i_word align_word(input rv32i_word addr);
        return addr & ~rv32i_word'(3);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new pc/instr pair, hold it under a decode
// stall, or flush it on a redirect (flush wins over load and hold).
module if_id_reg
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       flush,
    input  logic       stall,
    input  fetch_pkt_t pkt,
    output logic       valid,
    output rv32i_word  pc,
    output rv32i_word  instr
);

    logic       valid_q, valid_d;
    fetch_pkt_t pkt_q, pkt_d;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pkt_d   = pkt;
        end else if (!(stall && valid_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pkt_q   <= '{pc: '0, instr: NOP_INSTR};
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pkt_q.pc;
    assign instr = pkt_q.instr;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the single-outstanding imem handshake and feeds
// IF/ID, absorbing one word in a skid register while decode is stalled.
module fetch_stage
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h4000_0000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      redirect,
    input  rv32i_word redirect_pc,
    output rv32i_word imem_address,
    output logic      imem_read,
    input  rv32i_word imem_rdata,
    input  logic      imem_resp,
    output logic      if_id_valid,
    output rv32i_word if_id_pc,
    output rv32i_word if_id_instr
);

    fetch_state_t state_q, state_d;
    rv32i_word    pc_q, pc_d;
    rv32i_word    tgt_q, tgt_d;
    fetch_pkt_t   skid_q, skid_d;
    logic         drop_q, drop_d;
    logic         busy_q, busy_d;
    logic         drop_rst;
    logic         load;
    fetch_pkt_t   load_pkt;
    rv32i_word    redirect_tgt;

    assign redirect_tgt = align_word(redirect_pc);
    assign imem_read    = (state_q != FULL);
    assign imem_address = pc_q;

    // busy_q: memory has seen a request it has not answered yet. A reset that
    // lands on such a request arms drop_q so the stale word is thrown away.
    assign drop_rst = (drop_q | busy_q) & ~imem_resp;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        skid_d   = skid_q;
        drop_d   = drop_q & ~imem_resp;
        busy_d   = imem_read & ~imem_resp;
        load     = 1'b0;
        load_pkt = '{pc: pc_q, instr: imem_rdata};

        unique case (state_q)
            REQ: begin
                if (imem_resp) begin
                    if (redirect || drop_q) begin
                        pc_d = redirect ? redirect_tgt : pc_q;
                    end else if (!if_id_valid || !stall) begin
                        load = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else begin
                        skid_d  = '{pc: pc_q, instr: imem_rdata};
                        pc_d    = pc_q + 32'd4;
                        state_d = FULL;
                    end
                end else if (redirect) begin
                    tgt_d   = redirect_tgt;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    tgt_d = redirect_tgt;
                end
                if (imem_resp) begin
                    pc_d    = redirect ? redirect_tgt : tgt_q;
                    state_d = REQ;
                end
            end
            FULL: begin
                if (redirect) begin
                    skid_d  = '0;
                    pc_d    = redirect_tgt;
                    state_d = REQ;
                end else if (!stall) begin
                    load     = 1'b1;
                    load_pkt = skid_q;
                    state_d  = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            skid_q  <= '0;
            drop_q  <= drop_rst;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            skid_q  <= skid_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .flush (redirect),
        .stall (stall),
        .pkt   (load_pkt),
        .valid (if_id_valid),
        .pc    (if_id_pc),
        .instr (if_id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a responding instruction memory, directed corner cases
// and random stall/redirect traffic checked against the in-order PC stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          consumed;
    logic [31:0] exp_q[$];
    logic [31:0] cap_log[$];

    int          mem_dmin;
    int          mem_dmax;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_cap;
    bit          mem_rst_seen;

    // Every address holds a distinct word, so a wrong address gives a wrong word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected program order from a fetch target: sequential words, wrapping at 2^32.
    task automatic refill(input logic [31:0] start);
        logic [31:0] base;
        base = start & ~32'h3;
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        step();
        redirect    = 1'b1;
        redirect_pc = tgt;
        refill(tgt);
        step();
        redirect    = 1'b0;
    endtask

    task automatic wait_caps(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cap_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Instruction memory: latches a request, answers after mem_cnt cycles.
    initial begin
        imem_resp    = 1'b0;
        imem_rdata   = 32'h0;
        mem_busy     = 1'b0;
        mem_cnt      = 0;
        mem_cap      = 32'h0;
        mem_rst_seen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            imem_resp  = 1'b0;
            imem_rdata = $urandom;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_resp  = 1'b1;
                    imem_rdata = word_at(mem_cap);
                    mem_busy   = 1'b0;
                end
            end
            @(negedge clk);
            if (rst) mem_rst_seen = 1'b1;
            if (!imem_resp && !mem_busy && imem_read && !rst) begin
                mem_busy     = 1'b1;
                mem_cap      = imem_address;
                mem_cnt      = int'($urandom_range(mem_dmax, mem_dmin));
                mem_rst_seen = 1'b0;
                cap_log.push_back(imem_address);
                check("addr_align", {30'h0, imem_address[1:0]}, 32'h0);
            end else if (mem_busy && imem_read && !rst && !mem_rst_seen) begin
                check("addr_stable", imem_address, mem_cap);
            end
        end
    end

    // Monitor: an instruction leaves IF/ID when valid, not stalled, not flushed.
    always @(negedge clk) begin
        if (!rst && if_id_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver_extra: got pc %h with no instruction expected", if_id_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("if_id_pc", if_id_pc, e);
                check("if_id_instr", if_id_instr, word_at(e));
                consumed++;
            end
        end
    end

    initial begin
        bit ok;
        int base_consumed;
        checks      = 0;
        errors      = 0;
        consumed    = 0;
        mem_dmin    = 1;
        mem_dmax    = 1;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        refill(RESET_PC);

        @(posedge clk);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_imem_read", {31'h0, imem_read}, 32'h1);
        check("rst_imem_addr", imem_address, RESET_PC);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_if_id_pc", if_id_pc, 32'h0);
        check("rst_if_id_instr", if_id_instr, 32'h0000_0013);

        // Back-to-back fetches, one response every second cycle
        repeat (12) step();

        // Decode stall long enough to fill the skid register
        stall = 1'b1;
        repeat (6) step();
        @(negedge clk);
        check("full_read_low", {31'h0, imem_read}, 32'h0);
        check("full_valid_held", {31'h0, if_id_valid}, 32'h1);
        step();
        stall = 1'b0;
        repeat (8) step();

        // Redirect while a fetch is outstanding
        mem_dmin = 3;
        mem_dmax = 3;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_busy && mem_cnt >= 2) begin ok = 1'b1; break; end
        end
        check("wait_outstanding", {31'h0, ok}, 32'h1);
        do_redirect(32'h4000_0100);
        repeat (15) step();

        // Redirect in the same cycle as the response
        mem_dmin = 2;
        mem_dmax = 2;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_busy && mem_cnt == 1) begin ok = 1'b1; break; end
        end
        check("wait_resp_slot", {31'h0, ok}, 32'h1);
        do_redirect(32'h4000_0200);
        @(negedge clk);
        check("resp_redir_valid", {31'h0, if_id_valid}, 32'h0);
        check("resp_redir_addr", imem_address, 32'h4000_0200);
        repeat (10) step();

        // Redirect while the skid register is full
        stall = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!imem_read) begin ok = 1'b1; break; end
        end
        check("wait_full", {31'h0, ok}, 32'h1);
        do_redirect(32'h4000_0300);
        @(negedge clk);
        check("full_redir_valid", {31'h0, if_id_valid}, 32'h0);
        check("full_redir_read", {31'h0, imem_read}, 32'h1);
        check("full_redir_addr", imem_address, 32'h4000_0300);
        step();
        stall = 1'b0;
        repeat (10) step();

        // Misaligned target is word-aligned; fetch wraps past the top of memory
        mem_dmin = 1;
        mem_dmax = 1;
        do_redirect(32'h1234_5677);
        cap_log.delete();
        wait_caps(1, 30, ok);
        check("misalign_seen", {31'h0, ok}, 32'h1);
        if (ok) check("misalign_addr", cap_log[0], 32'h1234_5674);
        repeat (4) step();
        do_redirect(32'hFFFF_FFFC);
        cap_log.delete();
        wait_caps(2, 30, ok);
        check("wrap_seen", {31'h0, ok}, 32'h1);
        if (ok) begin
            check("wrap_first", cap_log[0], 32'hFFFF_FFFC);
            check("wrap_next", cap_log[1], 32'h0000_0000);
        end
        repeat (6) step();

        // Reset while discarding, with the stale response still to come
        mem_dmin = 6;
        mem_dmax = 6;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_busy && mem_cnt >= 5) begin ok = 1'b1; break; end
        end
        check("wait_long_fetch", {31'h0, ok}, 32'h1);
        mem_dmin = 1;
        mem_dmax = 1;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0400;
        refill(32'h4000_0400);
        step();
        redirect = 1'b0;
        rst      = 1'b1;
        refill(RESET_PC);
        step();
        rst = 1'b0;
        cap_log.delete();
        @(negedge clk);
        check("rst2_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst2_read", {31'h0, imem_read}, 32'h1);
        check("rst2_addr", imem_address, RESET_PC);
        wait_caps(1, 30, ok);
        check("rst2_refetch_seen", {31'h0, ok}, 32'h1);
        if (ok) check("rst2_refetch_addr", cap_log[0], RESET_PC);
        repeat (10) step();

        // Random stalls, redirects and memory latency
        mem_dmin = 1;
        mem_dmax = 4;
        base_consumed = consumed;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step();
            stall    = ($urandom_range(99) < 30);
            redirect = 1'b0;
            if ($urandom_range(99) < 4) begin
                logic [31:0] t;
                t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : $urandom;
                redirect    = 1'b1;
                redirect_pc = t;
                refill(t);
            end
        end
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (20) step();
        check("random_progress", {31'h0, (consumed - base_consumed) >= 100}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
